regcep_ctrl: RTL and testbench

- Controller and arbiter for the single-port 8192x16 cepstral feature store (MFCC vectors, 26 coefficients per frame, up to 256 frames).
- Accepts the coefficient stream from the MFCC extractor and packs it frame-major at address frame*26+coef.
- Serves random-access reads from the recognition/distance stage.
- Arbitrates the one memory port round-robin and tracks how many complete frames are valid.

---
 rtl/regcep_ctrl.sv | 128 ++++++++++++
 tb/tb_regcep_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/regcep_ctrl.sv
// Cepstral feature store controller: packs the MFCC coefficient stream frame-major
// and shares the single memory port round-robin with random-access readers.
module regcep_ctrl #(
  parameter int NCOEF      = 26,
  parameter int MAX_FRAMES = 256,
  parameter int AW         = 13,
  parameter int DW         = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_start,
  input  logic          wr_end,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          rd_req,
  input  logic [7:0]    rd_frame,
  input  logic [4:0]    rd_coef,
  output logic          rd_gnt,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rd_err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_dout,
  output logic [8:0]    frame_count,
  output logic          capturing
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t        state, state_nx;
  logic [8:0]    frame_q;
  logic [4:0]    coef_q;
  logic          rr_rd;
  logic [AW-1:0] addr_q;
  logic          rd_valid_q, rd_err_q;

  logic wr_req, rd_legal, rd_bad, contend, rd_take, wr_take, last_coef;

  // frame*26 as (f<<4)+(f<<3)+(f<<1); peaks at 255*26+25 = 6655, inside 13 bits
  function automatic logic [AW-1:0] frame_base(input logic [7:0] f);
    logic [AW-1:0] fx;
    fx = AW'(f);
    return (fx << 4) + (fx << 3) + (fx << 1);
  endfunction

  always_comb begin
    wr_req    = (state == CAPTURE) && wr_valid && !wr_start && !wr_end &&
                (frame_q != 9'(MAX_FRAMES)) && !reset;
    rd_legal  = rd_req && ({1'b0, rd_frame} < frame_q) && (rd_coef < 5'(NCOEF)) && !reset;
    rd_bad    = rd_req && !rd_legal && !reset;
    contend   = wr_req && rd_legal;
    rd_take   = rd_legal && (!wr_req || rr_rd);
    wr_take   = wr_req && !(rd_legal && rr_rd);
    last_coef = (coef_q == 5'(NCOEF - 1));
  end

  // Illegal reads never touch the port, so they do not block the writer.
  assign wr_ready = wr_take;
  assign rd_gnt   = rd_take || rd_bad;
  assign mem_wren = wr_take;
  assign mem_din  = wr_data;

  always_comb begin
    mem_addr = addr_q;
    if (wr_take)
      mem_addr = frame_base(frame_q[7:0]) + AW'(coef_q);
    else if (rd_take)
      mem_addr = frame_base(rd_frame) + AW'(rd_coef);
  end

  always_comb begin
    state_nx  = state;
    capturing = (state == CAPTURE);
    case (state)
      IDLE, DONE: if (wr_start) state_nx = CAPTURE;
      CAPTURE: begin
        if (wr_start)
          state_nx = CAPTURE;
        else if (wr_end)
          state_nx = DONE;
        else if (wr_take && last_coef && frame_q == 9'(MAX_FRAMES - 1))
          state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      frame_q    <= '0;
      coef_q     <= '0;
      rr_rd      <= 1'b1;
      addr_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      state      <= state_nx;
      addr_q     <= mem_addr;
      rd_valid_q <= rd_take || rd_bad;
      rd_err_q   <= rd_bad;
      if (contend)
        rr_rd <= !rr_rd;
      if (wr_start) begin
        frame_q <= '0;
        coef_q  <= '0;
      end else if (wr_end) begin
        coef_q <= '0;
      end else if (wr_take) begin
        if (last_coef) begin
          coef_q  <= '0;
          frame_q <= frame_q + 9'd1;
        end else begin
          coef_q <= coef_q + 5'd1;
        end
      end
    end
  end

  assign rd_valid    = rd_valid_q;
  assign rd_err      = rd_err_q;
  assign rd_data     = (rd_valid_q && !rd_err_q) ? mem_dout : '0;
  assign frame_count = frame_q;

endmodule

// File: tb/tb_regcep_ctrl.sv
// Directed bench for regcep_ctrl with a behavioural 8192x16 registered-read store.
module tb_regcep_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_start, wr_end, wr_valid;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        rd_req;
  logic [7:0]  rd_frame;
  logic [4:0]  rd_coef;
  logic        rd_gnt, rd_valid, rd_err;
  logic [15:0] rd_data;
  logic [12:0] mem_addr;
  logic [15:0] mem_din, mem_dout;
  logic        mem_wren;
  logic [8:0]  frame_count;
  logic        capturing;

  int errors = 0;
  int checks = 0;

  logic [15:0] store [0:8191];

  regcep_ctrl dut (
    .clk(clk), .reset(reset),
    .wr_start(wr_start), .wr_end(wr_end), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_frame(rd_frame), .rd_coef(rd_coef), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wren(mem_wren), .mem_dout(mem_dout),
    .frame_count(frame_count), .capturing(capturing)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wren) store[mem_addr] <= mem_din;
    else          mem_dout <= store[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
  endtask

  task automatic pulse_end();
    wr_end = 1'b1;
    tick();
    wr_end = 1'b0;
  endtask

  task automatic stream(input int n, input int base, input int addr0);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = 16'(base + i);
      @(negedge clk);
      chk("wr_ready", wr_ready, 1);
      chk("wr_addr", mem_addr, addr0 + i);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input int f, input int c, input logic exp_err, input int exp_data);
    rd_req   = 1'b1;
    rd_frame = 8'(f);
    rd_coef  = 5'(c);
    @(negedge clk);
    chk("rd_gnt", rd_gnt, 1);
    if (!exp_err) begin
      chk("rd_addr", mem_addr, f * 26 + c);
      chk("rd_wren", mem_wren, 0);
    end
    tick();
    rd_req = 1'b0;
    chk("rd_valid", rd_valid, 1);
    chk("rd_err", rd_err, exp_err);
    chk("rd_data", rd_data, exp_data);
  endtask

  initial begin
    reset = 1'b1; wr_start = 0; wr_end = 0; wr_valid = 0; wr_data = 0;
    rd_req = 0; rd_frame = 0; rd_coef = 0;

    // outputs held off during reset even with requests present
    #2;
    wr_valid = 1'b1; rd_req = 1'b1;
    #1;
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_gnt", rd_gnt, 0);
    chk("rst_wren", mem_wren, 0);
    chk("rst_fc", frame_count, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_capt", capturing, 0);
    wr_valid = 0; rd_req = 0;
    tick();
    reset = 1'b0;
    tick();

    // capture two frames with no reads
    wr_valid = 1'b1;
    wr_start = 1'b1;
    @(negedge clk);
    chk("start_no_wr", wr_ready, 0);
    tick();
    wr_start = 1'b0;
    wr_valid = 1'b0;
    chk("capt_on", capturing, 1);
    stream(52, 0, 0);
    chk("fc_2", frame_count, 2);
    pulse_end();
    chk("done_capt", capturing, 0);
    wr_valid = 1'b1;
    @(negedge clk);
    chk("done_no_wr", wr_ready, 0);
    tick();
    wr_valid = 1'b0;
    do_read(1, 25, 1'b0, 16'h0033);
    do_read(0, 25, 1'b0, 16'h0019);

    // back-to-back reads give back-to-back responses
    rd_req = 1'b1; rd_frame = 0; rd_coef = 7;
    tick();
    rd_frame = 1; rd_coef = 0;
    chk("b2b_v0", rd_valid, 1);
    chk("b2b_d0", rd_data, 16'h0007);
    tick();
    rd_req = 1'b0;
    chk("b2b_v1", rd_valid, 1);
    chk("b2b_d1", rd_data, 16'h001A);
    tick();
    chk("idle_v", rd_valid, 0);

    // partial frame is discarded on wr_end
    pulse_start();
    chk("restart_fc", frame_count, 0);
    stream(30, 16'h0100, 0);
    chk("part_fc_pre", frame_count, 1);
    pulse_end();
    chk("part_fc", frame_count, 1);
    do_read(1, 0, 1'b1, 0);
    do_read(0, 26, 1'b1, 0);
    do_read(0, 4, 1'b0, 16'h0104);

    // illegal read shares the cycle with a write
    pulse_start();
    stream(52, 16'h0200, 0);
    wr_valid = 1'b1; wr_data = 16'h02AA;
    rd_req = 1'b1; rd_frame = 5; rd_coef = 3;
    @(negedge clk);
    chk("ill_wr_ready", wr_ready, 1);
    chk("ill_rd_gnt", rd_gnt, 1);
    chk("ill_wren", mem_wren, 1);
    chk("ill_addr", mem_addr, 52);
    tick();
    wr_valid = 1'b0; rd_req = 1'b0;
    chk("ill_valid", rd_valid, 1);
    chk("ill_err", rd_err, 1);
    chk("ill_data", rd_data, 0);

    // contention from reset: reader first, then alternate
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pulse_start();
    stream(26, 16'h0300, 0);
    begin
      int nw;
      nw = 0;
      for (int k = 0; k < 4; k++) begin
        logic exp_r;
        exp_r    = (k % 2 == 0);
        wr_valid = 1'b1; wr_data = 16'(16'h0400 + nw);
        rd_req   = 1'b1; rd_frame = 0; rd_coef = 2;
        @(negedge clk);
        chk("arb_rd", rd_gnt, exp_r);
        chk("arb_wr", wr_ready, !exp_r);
        if (!exp_r) begin
          chk("arb_waddr", mem_addr, 26 + nw);
          nw++;
        end
        tick();
        chk("arb_rvalid", rd_valid, exp_r);
        if (exp_r) chk("arb_rdata", rd_data, 16'h0302);
      end
    end
    wr_valid = 1'b0; rd_req = 1'b0;
    do_read(1, 1, 1'b1, 0);

    // async reset one cycle after a read grant
    rd_req = 1'b1; rd_frame = 0; rd_coef = 1;
    tick();
    rd_req = 1'b0;
    chk("pre_rst_valid", rd_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", rd_valid, 0);
    chk("arst_fc", frame_count, 0);
    chk("arst_capt", capturing, 0);
    tick();
    reset = 1'b0;
    tick();

    // fill to capacity
    pulse_start();
    stream(256 * 26, 0, 0);
    chk("cap_fc", frame_count, 256);
    chk("cap_done", capturing, 0);
    wr_valid = 1'b1;
    @(negedge clk);
    chk("cap_no_wr", wr_ready, 0);
    chk("cap_no_wren", mem_wren, 0);
    tick();
    wr_valid = 1'b0;
    do_read(255, 25, 1'b0, 16'h19FF);
    do_read(128, 0, 1'b0, 16'h0D00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
